serialtopar_align: RTL and testbench
====================================

# serialtopar_align

Parametrised single-clock serial-to-parallel converter with comma-based word alignment, for the PHY receive path. Unlike the fixed 8-bit two-clock converter, it runs entirely on the bit clock and finds the word boundary itself by searching for a comma at any bit offset. It generates its own word strobe and declares lock after a programmable number of aligned commas. It outputs parallel words with a valid bit for non-comma data, and can optionally drop lock on persistent misaligned commas.

## Interface
- WIDTH, 8, word width in bits (≥2)
- COMMA, 8'hBC, WIDTH-bit idle/alignment symbol
- LOCK_CNT, 4, consecutive aligned commas required to enter LOCKED (≥1)
- SLIP_MAX, 3, consecutive misaligned commas that force loss of lock (≥1; used only with SERIALTOPAR_SLIP_EN)
- clk_nf  input  1  bit-rate clock, WIDTH × word rate; the only clock
- reset  input  1  asynchronous, active-high reset
- in  input  1  serial data, MSB first, sampled on rising clk_nf
- data_par  output  WIDTH  last aligned word
- valid_par  output  1  data_par holds a non-comma word while LOCKED
- word_stb  output  1  one-cycle pulse on each word boundary in VERIFY/LOCKED
- locked  output  1  high in LOCKED state

## Operation
- Shift register: shift_reg = {buffer[WIDTH-2:0], in}; buffer <= shift_reg every cycle.
- phase counter, clog2(WIDTH) bits, counts 0..WIDTH-1 and wraps. Boundary = (phase == WIDTH-1).
- The FSM has three states: HUNT, VERIFY, LOCKED. Reset state is HUNT.
- HUNT:
  - shift_reg is compared with COMMA every cycle.
  - On a match, phase <= 0 and comma_cnt <= 1.
  - The FSM then goes to VERIFY, or directly to LOCKED if LOCK_CNT == 1.
- VERIFY:
  - Only boundaries are checked.
  - If shift_reg == COMMA, comma_cnt increments. When it reaches LOCK_CNT, the FSM goes to LOCKED.
  - If the boundary word is not COMMA, the FSM returns to HUNT and comma_cnt <= 0.
  - valid_par stays 0.
- LOCKED:
  - At each boundary, data_par <= shift_reg and valid_par <= (shift_reg != COMMA).
  - locked = 1.
- data_par is also updated at boundaries in VERIFY, with valid_par = 0. In HUNT, data_par holds its value.
- comma_cnt saturates at LOCK_CNT. Its width is clog2(LOCK_CNT+1).
- When the FSM leaves LOCKED: valid_par <= 0 on the same edge, locked falls, and data_par holds.
- The phase counter is not reset on entering LOCKED. Alignment is fixed by the last HUNT match.

## Timing
- Reset values: data_par = 0, valid_par = 0, word_stb = 0, locked = 0, state = HUNT, all counters = 0. Reset takes effect immediately, not on a clock edge.
- Reset mid-word or mid-lock: everything is discarded; the search restarts on the first edge after reset deasserts.
- Latency: the word whose last bit is sampled at edge k appears on data_par/valid_par after edge k. It is held for WIDTH cycles.
- word_stb is high for the cycle following each boundary edge, coincident with the data_par update.
- First lock: the HUNT comma completes at edge k. Aligned commas complete at k+WIDTH·n. locked rises after edge k+WIDTH·(LOCK_CNT-1).
- The first valid_par=1 occurs at the first non-comma boundary after lock.
- In HUNT, a match on the first edge after reset is accepted. Shift-register contents after reset are zeros, so COMMA=0 is unsupported.
- If a misaligned comma and a boundary event coincide: a boundary match counts as aligned and takes priority.

## Configuration
- SERIALTOPAR_SLIP_EN defined:
  - In LOCKED, a COMMA match at a non-boundary phase increments slip_cnt (saturating, clog2(SLIP_MAX+1) bits).
  - An aligned comma clears slip_cnt.
  - When slip_cnt reaches SLIP_MAX, the FSM goes to HUNT, valid_par <= 0, and locked <= 0. A fresh search starts on the next edge.
- Not defined:
  - LOCKED is sticky until reset.
  - slip_cnt logic is absent.
  - SLIP_MAX is ignored.

## Test plan
- Reset, then 4× 0xBC aligned from edge 8 -> locked=1 after edge 32; valid_par=0; word_stb every 8 cycles.
- After lock, send 0x5A, 0xBC, 0x3C -> data_par 0x5A/valid 1, then 0xBC/valid 0, then 0x3C/valid 1. Each update follows the last bit's edge.
- Stream starting with 3 garbage bits, then 0xBC×4, then 0xA5 -> lock at correct offset; data_par=0xA5, valid_par=1.
- 2× 0xBC, then 0x00 at the boundary -> return to HUNT, locked stays 0. A following 0xBC×4 then locks.
- With SERIALTOPAR_SLIP_EN: when locked, insert 3 commas shifted by 3 bits -> locked and valid_par drop after the 3rd. Without the macro, locked stays 1.
- Assert reset mid-word while locked -> all outputs 0 immediately; relock needs 4 fresh commas.

Source files
------------

// File: rtl/serialtopar_align.sv
// Bit-clock serial-to-parallel converter that finds its own word boundary by comma search.
// Define SERIALTOPAR_SLIP_EN to drop lock after SLIP_MAX consecutive misaligned commas.
module serialtopar_align #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] COMMA    = 8'hBC,
   parameter int               LOCK_CNT = 4,
   parameter int               SLIP_MAX = 3
) (
   input  logic             clk_nf,
   input  logic             reset,
   input  logic             in,
   output logic [WIDTH-1:0] data_par,
   output logic             valid_par,
   output logic             word_stb,
   output logic             locked
);
   localparam int PW = $clog2(WIDTH);
   localparam int CW = $clog2(LOCK_CNT + 1);
   localparam logic [PW-1:0] PHASE_LAST = PW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_LOCK   = CW'(LOCK_CNT);
   localparam logic [CW-1:0] CNT_LAST   = CW'(LOCK_CNT - 1);

   if (WIDTH < 2 || LOCK_CNT < 1 || SLIP_MAX < 1) begin : g_bad_params
      $error("serialtopar_align: needs WIDTH>=2, LOCK_CNT>=1, SLIP_MAX>=1");
   end

   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-2:0] buffer;
   logic [WIDTH-1:0] shift_reg;
   logic [PW-1:0]    phase, phase_nxt;
   logic [CW-1:0]    comma_cnt, comma_cnt_nxt;
   logic             is_comma, boundary, word_out;

`ifdef SERIALTOPAR_SLIP_EN
   localparam int SW = $clog2(SLIP_MAX + 1);
   localparam logic [SW-1:0] SLIP_LAST = SW'(SLIP_MAX - 1);
   logic [SW-1:0] slip_cnt, slip_cnt_nxt;
`endif

   assign shift_reg = {buffer, in};
   assign is_comma  = (shift_reg == COMMA);
   assign boundary  = (phase == PHASE_LAST);
   assign word_out  = boundary && (state != HUNT);
   assign locked    = (state == LOCKED);

   always_ff @(posedge clk_nf or posedge reset) begin
      if (reset) state <= HUNT;
      else       state <= state_nxt;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt     = state;
      phase_nxt     = boundary ? '0 : phase + 1'b1;
      comma_cnt_nxt = comma_cnt;
`ifdef SERIALTOPAR_SLIP_EN
      slip_cnt_nxt  = slip_cnt;
`endif
      case (state)
         HUNT: begin
            if (is_comma) begin
               phase_nxt     = '0;
               comma_cnt_nxt = CW'(1);
               state_nxt     = (LOCK_CNT == 1) ? LOCKED : VERIFY;
            end
         end
         VERIFY: begin
            if (boundary) begin
               if (is_comma) begin
                  if (comma_cnt != CNT_LOCK) comma_cnt_nxt = comma_cnt + 1'b1;
                  if (comma_cnt == CNT_LAST) state_nxt = LOCKED;
               end else begin
                  comma_cnt_nxt = '0;
                  state_nxt     = HUNT;
               end
            end
         end
         LOCKED: begin
`ifdef SERIALTOPAR_SLIP_EN
            // An aligned comma wins over a coincident slip and clears the count.
            if (is_comma) begin
               if (boundary) begin
                  slip_cnt_nxt = '0;
               end else if (slip_cnt == SLIP_LAST) begin
                  slip_cnt_nxt  = '0;
                  comma_cnt_nxt = '0;
                  state_nxt     = HUNT;
               end else begin
                  slip_cnt_nxt = slip_cnt + 1'b1;
               end
            end
`endif
         end
         default: state_nxt = HUNT;
      endcase
   end

   always_ff @(posedge clk_nf or posedge reset) begin
      if (reset) begin
         buffer    <= '0;
         phase     <= '0;
         comma_cnt <= '0;
         data_par  <= '0;
         valid_par <= 1'b0;
         word_stb  <= 1'b0;
`ifdef SERIALTOPAR_SLIP_EN
         slip_cnt  <= '0;
`endif
      end else begin
         // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
         buffer    <= shift_reg[WIDTH-2:0];
         phase     <= phase_nxt;
         comma_cnt <= comma_cnt_nxt;
         word_stb  <= word_out;
`ifdef SERIALTOPAR_SLIP_EN
         slip_cnt  <= slip_cnt_nxt;
`endif
         if (word_out) begin
            data_par  <= shift_reg;
            valid_par <= (state == LOCKED) && !is_comma;
         end
         // Leaving LOCKED (or never reaching it) forces valid low; data_par holds.
         if (state_nxt != LOCKED) valid_par <= 1'b0;
      end
   end

endmodule

// File: tb/tb_serialtopar_align.sv
// Scoreboard bench for serialtopar_align: expected words are queued as bits are driven
// and popped on each word_stb; lock, slip and reset behaviour checked inline per task.
module tb_serialtopar_align;
   localparam logic [7:0] COMMA = 8'hBC;

   typedef struct packed {
      logic [7:0] data;
      logic       valid;
   } exp_t;

   logic       clk_nf = 1'b0;
   logic       reset  = 1'b0;
   logic       in     = 1'b0;
   logic [7:0] data_par;
   logic       valid_par, word_stb, locked;

   exp_t sb[$];
   int   tests_run = 0;
   int   fails     = 0;
   int   stb_count = 0;

   serialtopar_align #(
      .WIDTH(8), .COMMA(8'hBC), .LOCK_CNT(4), .SLIP_MAX(3)
   ) dut (
      .clk_nf   (clk_nf),
      .reset    (reset),
      .in       (in),
      .data_par (data_par),
      .valid_par(valid_par),
      .word_stb (word_stb),
      .locked   (locked)
   );

   always #5 clk_nf = ~clk_nf;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required bench completion");
      $fatal(1, "watchdog expired");
   end

   // Drive one bit, let it be sampled, then check any word the DUT emits.
   task automatic send_bit(input logic b);
      exp_t e;
      in = b;
      @(posedge clk_nf);
      #1;
      if (word_stb === 1'b1) begin
         stb_count++;
         tests_run++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: word_stb with data_par=%h valid_par=%b, required no word",
                     data_par, valid_par);
         end else begin
            e = sb.pop_front();
            if (data_par !== e.data || valid_par !== e.valid) begin
               fails++;
               $display("FAIL sb_word: got data_par=%h valid_par=%b, required %h/%b",
                        data_par, valid_par, e.data, e.valid);
            end
         end
      end
   endtask

   task automatic send_word(input logic [7:0] w, input bit push, input logic v);
      if (push) sb.push_back(exp_t'{w, v});
      for (int i = 7; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic sb_drained(input string name);
      tests_run++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL %s_drain: %0d expected words never emitted, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   // Assert reset between edges; outputs must clear without any clock edge.
   task automatic apply_reset();
      reset = 1'b1;
      #1;
      tests_run++;
      if (data_par !== 8'h00 || valid_par !== 1'b0 || word_stb !== 1'b0 || locked !== 1'b0) begin
         fails++;
         $display("FAIL reset_async: got data=%h valid=%b stb=%b locked=%b, required all 0",
                  data_par, valid_par, word_stb, locked);
      end
      @(posedge clk_nf);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
   endtask

   task automatic test_lock();
      logic [7:0] w;
      w = COMMA;
      apply_reset();
      stb_count = 0;
      send_word(COMMA, 1'b0, 1'b0);
      send_word(COMMA, 1'b1, 1'b0);
      send_word(COMMA, 1'b1, 1'b0);
      sb.push_back(exp_t'{COMMA, 1'b0});
      for (int i = 7; i >= 1; i--) send_bit(w[i]);
      tests_run++;
      if (locked !== 1'b0) begin
         fails++;
         $display("FAIL lock_early: locked=%b after edge 31, required 0", locked);
      end
      send_bit(w[0]);
      tests_run++;
      if (locked !== 1'b1 || valid_par !== 1'b0) begin
         fails++;
         $display("FAIL lock_edge32: locked=%b valid=%b, required 1/0", locked, valid_par);
      end
      tests_run++;
      if (stb_count != 3) begin
         fails++;
         $display("FAIL lock_stb_count: %0d strobes in 32 edges, required 3", stb_count);
      end
      sb_drained("lock");
   endtask

   task automatic test_data();
      logic [7:0] w;
      w = 8'h5A;
      sb.push_back(exp_t'{w, 1'b1});
      for (int i = 7; i >= 1; i--) send_bit(w[i]);
      tests_run++;
      if (data_par !== COMMA || valid_par !== 1'b0) begin
         fails++;
         $display("FAIL data_hold: data=%h valid=%b before last bit, required bc/0",
                  data_par, valid_par);
      end
      send_bit(w[0]);
      send_word(COMMA, 1'b1, 1'b0);
      send_word(8'h3C, 1'b1, 1'b1);
      sb_drained("data");
   endtask

   task automatic test_garbage_align();
      logic [7:0] w;
      w = COMMA;
      apply_reset();
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_word(COMMA, 1'b0, 1'b0);
      send_word(COMMA, 1'b1, 1'b0);
      send_word(COMMA, 1'b1, 1'b0);
      sb.push_back(exp_t'{COMMA, 1'b0});
      for (int i = 7; i >= 1; i--) send_bit(w[i]);
      tests_run++;
      if (locked !== 1'b0) begin
         fails++;
         $display("FAIL garbage_early: locked=%b, required 0", locked);
      end
      send_bit(w[0]);
      send_word(8'hA5, 1'b1, 1'b1);
      tests_run++;
      if (locked !== 1'b1 || data_par !== 8'hA5 || valid_par !== 1'b1) begin
         fails++;
         $display("FAIL garbage_word: locked=%b data=%h valid=%b, required 1/a5/1",
                  locked, data_par, valid_par);
      end
      sb_drained("garbage");
   endtask

   task automatic test_verify_fail();
      logic [7:0] w;
      w = COMMA;
      apply_reset();
      send_word(COMMA, 1'b0, 1'b0);
      send_word(COMMA, 1'b1, 1'b0);
      send_word(8'h00, 1'b1, 1'b0);
      tests_run++;
      if (locked !== 1'b0) begin
         fails++;
         $display("FAIL verify_drop: locked=%b after bad boundary, required 0", locked);
      end
      send_word(COMMA, 1'b0, 1'b0);
      send_word(COMMA, 1'b1, 1'b0);
      send_word(COMMA, 1'b1, 1'b0);
      sb.push_back(exp_t'{COMMA, 1'b0});
      for (int i = 7; i >= 1; i--) send_bit(w[i]);
      tests_run++;
      if (locked !== 1'b0) begin
         fails++;
         $display("FAIL verify_relock_early: locked=%b, required 0", locked);
      end
      send_bit(w[0]);
      tests_run++;
      if (locked !== 1'b1) begin
         fails++;
         $display("FAIL verify_relock: locked=%b, required 1", locked);
      end
      sb_drained("verify");
   endtask

   // Three commas offset by 3 bits from the locked alignment.
   task automatic test_slip();
      logic [31:0] s;
      bit          slip_en;
`ifdef SERIALTOPAR_SLIP_EN
      slip_en = 1'b1;
`else
      slip_en = 1'b0;
`endif
      s = {3'b000, COMMA, COMMA, COMMA, 5'b00000};
      sb.push_back(exp_t'{8'h17, 1'b1});
      sb.push_back(exp_t'{8'h97, 1'b1});
      sb.push_back(exp_t'{8'h97, 1'b1});
      if (!slip_en) sb.push_back(exp_t'{8'h80, 1'b1});
      for (int k = 1; k <= 32; k++) begin
         send_bit(s[32-k]);
         if (k == 26) begin
            tests_run++;
            if (locked !== 1'b1) begin
               fails++;
               $display("FAIL slip_before: locked=%b after 2nd slip, required 1", locked);
            end
         end
         if (k == 27) begin
            tests_run++;
            if (locked !== !slip_en || valid_par !== !slip_en) begin
               fails++;
               $display("FAIL slip_third: locked=%b valid=%b, required %b/%b",
                        locked, valid_par, !slip_en, !slip_en);
            end
         end
      end
      tests_run++;
      if (slip_en ? (locked !== 1'b0 || data_par !== 8'h97 || valid_par !== 1'b0)
                  : (locked !== 1'b1 || data_par !== 8'h80 || valid_par !== 1'b1)) begin
         fails++;
         $display("FAIL slip_after: locked=%b data=%h valid=%b, required slip_en=%b behaviour",
                  locked, data_par, valid_par, slip_en);
      end
      sb_drained("slip");
   endtask

   task automatic test_reset_mid_lock();
      apply_reset();
      send_word(COMMA, 1'b0, 1'b0);
      for (int n = 0; n < 3; n++) send_word(COMMA, 1'b1, 1'b0);
      send_word(8'h5A, 1'b1, 1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      tests_run++;
      if (locked !== 1'b1 || valid_par !== 1'b1) begin
         fails++;
         $display("FAIL midlock_pre: locked=%b valid=%b, required 1/1", locked, valid_par);
      end
      sb_drained("midlock_pre");
      apply_reset();
      send_word(COMMA, 1'b0, 1'b0);
      send_word(COMMA, 1'b1, 1'b0);
      send_word(COMMA, 1'b1, 1'b0);
      tests_run++;
      if (locked !== 1'b0) begin
         fails++;
         $display("FAIL midlock_3commas: locked=%b, required 0", locked);
      end
      send_word(COMMA, 1'b1, 1'b0);
      tests_run++;
      if (locked !== 1'b1) begin
         fails++;
         $display("FAIL midlock_relock: locked=%b after 4 commas, required 1", locked);
      end
      sb_drained("midlock");
   endtask

   initial begin
      @(posedge clk_nf);
      #1;
      test_reset();
      test_lock();
      test_data();
      test_garbage_align();
      test_verify_fail();
      test_slip();
      test_reset_mid_lock();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
